se_lookup_arbiter: RTL and testbench

Round-robin arbiter that shares the single MAC lookup engine between up to N frame-processing front-ends. Each front-end issues a level request carrying DMAC, SMAC and hash, then waits for ack/nak. The arbiter serialises the requests onto the engine port and routes the engine's ack/nak/result back to the granted front-end. A response timeout stops a stalled engine from hanging the front-ends.

---
 rtl/se_lookup_arbiter.sv | 171 +++++++++++++++++
 tb/tb_se_lookup_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/se_lookup_arbiter.sv
// Round-robin arbiter sharing one MAC lookup engine between N_REQ front-ends,
// with per-transaction response timeout and a saturating timeout counter.
module se_lookup_arbiter #(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req,
   input  logic [48*N_REQ-1:0]   req_dmac,
   input  logic [48*N_REQ-1:0]   req_smac,
   input  logic [12*N_REQ-1:0]   req_hash,
   output logic [N_REQ-1:0]      ack,
   output logic [N_REQ-1:0]      nak,
   output logic [15:0]           result,
   output logic                  eng_req,
   output logic [47:0]           eng_dmac,
   output logic [47:0]           eng_smac,
   output logic [11:0]           eng_hash,
   input  logic                  eng_ack,
   input  logic                  eng_nak,
   input  logic [15:0]           eng_result,
   output logic [N_REQ-1:0]      grant,
   output logic                  busy,
   output logic [15:0]           timeout_cnt
);
   // state   | meaning
   // IDLE    | no owner; arbitrate among pending requests
   // BUSY    | engine request outstanding for the granted front-end
   // RELEASE | one-cycle gap while the served front-end drops its req
   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_BUSY    = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [IW-1:0] last_grant;
   logic [IW-1:0] pick_idx;
   logic          pick_found;
   logic [IW:0]   cand_sum;
   logic [IW-1:0] cand;
   logic [47:0]   sel_dmac;
   logic [47:0]   sel_smac;
   logic [11:0]   sel_hash;
   logic [7:0]    wait_cnt;
   logic          wait_done;

   // Search upward from last_grant+1 with wrap-around; first set bit wins.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand_sum   = '0;
      cand       = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand_sum = {1'b0, last_grant} + (IW+1)'(i);
         if (cand_sum >= (IW+1)'(N_REQ)) begin
            cand_sum = cand_sum - (IW+1)'(N_REQ);
         end
         cand = cand_sum[IW-1:0];
         if (!pick_found && req[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_comb begin
      sel_dmac = '0;
      sel_smac = '0;
      sel_hash = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_idx == IW'(i)) begin
            sel_dmac = req_dmac[i*48 +: 48];
            sel_smac = req_smac[i*48 +: 48];
            sel_hash = req_hash[i*12 +: 12];
         end
      end
   end

   assign wait_done = (wait_cnt == 8'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (pick_found) state_nxt = S_BUSY;
         S_BUSY:    if (eng_ack || eng_nak || wait_done) state_nxt = S_RELEASE;
         S_RELEASE: state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state == S_BUSY) || (state == S_RELEASE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant  <= IW'(N_REQ - 1);
         grant       <= '0;
         ack         <= '0;
         nak         <= '0;
         result      <= '0;
         eng_req     <= 1'b0;
         eng_dmac    <= '0;
         eng_smac    <= '0;
         eng_hash    <= '0;
         wait_cnt    <= '0;
         timeout_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               ack <= '0;
               nak <= '0;
               if (pick_found) begin
                  grant      <= N_REQ'(1) << pick_idx;
                  last_grant <= pick_idx;
                  eng_req    <= 1'b1;
                  eng_dmac   <= sel_dmac;
                  eng_smac   <= sel_smac;
                  eng_hash   <= sel_hash;
                  wait_cnt   <= '0;
               end
            end
            S_BUSY: begin
               // A response on the timeout cycle takes priority over the timeout.
               if (eng_ack) begin
                  eng_req <= 1'b0;
                  ack     <= grant;
                  result  <= eng_result;
               end else if (eng_nak) begin
                  eng_req <= 1'b0;
                  nak     <= grant;
                  result  <= '0;
               end else if (wait_done) begin
                  eng_req <= 1'b0;
                  nak     <= grant;
                  result  <= '0;
                  if (timeout_cnt != 16'hFFFF) begin
                     timeout_cnt <= timeout_cnt + 16'd1;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            S_RELEASE: begin
               ack   <= '0;
               nak   <= '0;
               grant <= '0;
            end
            default: begin
               ack   <= '0;
               nak   <= '0;
               grant <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_se_lookup_arbiter.sv
// Bench for se_lookup_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_se_lookup_arbiter;
   localparam int N  = 4;
   localparam int TO = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req;
   logic [48*N-1:0] req_dmac;
   logic [48*N-1:0] req_smac;
   logic [12*N-1:0] req_hash;
   logic [N-1:0]    ack;
   logic [N-1:0]    nak;
   logic [15:0]     result;
   logic            eng_req;
   logic [47:0]     eng_dmac;
   logic [47:0]     eng_smac;
   logic [11:0]     eng_hash;
   logic            eng_ack;
   logic            eng_nak;
   logic [15:0]     eng_result;
   logic [N-1:0]    grant;
   logic            busy;
   logic [15:0]     timeout_cnt;

   logic [47:0] dm [N];
   logic [47:0] sm [N];
   logic [11:0] hs [N];

   int total = 0;
   int bad   = 0;
   bit rand_mode = 1'b0;

   se_lookup_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req(req),
      .req_dmac(req_dmac), .req_smac(req_smac), .req_hash(req_hash),
      .ack(ack), .nak(nak), .result(result),
      .eng_req(eng_req), .eng_dmac(eng_dmac), .eng_smac(eng_smac), .eng_hash(eng_hash),
      .eng_ack(eng_ack), .eng_nak(eng_nak), .eng_result(eng_result),
      .grant(grant), .busy(busy), .timeout_cnt(timeout_cnt)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         req_dmac[i*48 +: 48] = dm[i];
         req_smac[i*48 +: 48] = sm[i];
         req_hash[i*12 +: 12] = hs[i];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Transaction-level model: phase 0 idle, 1 engine outstanding, 2 release gap.
   int          m_phase, m_last, m_elapsed;
   logic [N-1:0] m_grant, m_ack, m_nak;
   logic        m_ereq;
   logic [47:0] m_dmac, m_smac;
   logic [11:0] m_hash;
   logic [15:0] m_result, m_tcnt;

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0; m_last = N - 1; m_elapsed = 0;
         m_grant = '0; m_ack = '0; m_nak = '0; m_ereq = 1'b0;
         m_dmac = '0; m_smac = '0; m_hash = '0; m_result = '0; m_tcnt = '0;
      end else begin
         case (m_phase)
            0: begin
               for (int k = 1; k <= N; k++) begin
                  int c;
                  c = (m_last + k) % N;
                  if (m_phase == 0 && req[c]) begin
                     m_phase = 1; m_last = c; m_elapsed = 0;
                     m_grant = '0; m_grant[c] = 1'b1; m_ereq = 1'b1;
                     m_dmac = dm[c]; m_smac = sm[c]; m_hash = hs[c];
                  end
               end
            end
            1: begin
               m_elapsed++;
               if (eng_ack) begin
                  m_ack = m_grant; m_result = eng_result;
               end else if (eng_nak) begin
                  m_nak = m_grant; m_result = '0;
               end else if (m_elapsed == TO) begin
                  m_nak = m_grant; m_result = '0;
                  if (m_tcnt != 16'hFFFF) m_tcnt = m_tcnt + 16'd1;
               end
               if ((m_ack | m_nak) != '0) begin
                  m_ereq = 1'b0; m_phase = 2;
               end
            end
            default: begin
               m_ack = '0; m_nak = '0; m_grant = '0; m_phase = 0;
            end
         endcase
      end
   end

   always @(posedge clk) begin
      #1;
      chk("grant", grant, m_grant);
      chk("eng_req", eng_req, m_ereq);
      chk("busy", busy, m_phase != 0);
      chk("ack", ack, m_ack);
      chk("nak", nak, m_nak);
      chk("timeout_cnt", timeout_cnt, m_tcnt);
      if (m_ereq) begin
         chk("eng_dmac", eng_dmac, m_dmac);
         chk("eng_smac", eng_smac, m_smac);
         chk("eng_hash", eng_hash, m_hash);
      end
      if ((m_ack | m_nak) != '0) chk("result", result, m_result);
   end

   // Random requesters and engine, reacting to the model's view of the outputs.
   always @(negedge clk) begin
      if (rand_mode) begin
         rst = ($urandom_range(0, 399) == 0);
         for (int i = 0; i < N; i++) begin
            if (m_ack[i] || m_nak[i]) begin
               req[i] = 1'b0;
            end else if (!req[i] && $urandom_range(0, 3) == 0) begin
               req[i] = 1'b1;
               dm[i] = {16'($urandom), 32'($urandom)};
               sm[i] = {16'($urandom), 32'($urandom)};
               hs[i] = 12'($urandom);
            end else if (m_grant[i] && $urandom_range(0, 19) == 0) begin
               req[i] = 1'b0;
            end
         end
         eng_result = 16'($urandom);
         if (m_ereq) begin
            int r;
            r = $urandom_range(0, 99);
            eng_ack = (r < 12) || (r >= 18 && r < 21);
            eng_nak = (r >= 12 && r < 21);
         end else begin
            eng_ack = ($urandom_range(0, 19) == 0);
            eng_nak = ($urandom_range(0, 19) == 0);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_grant(output int idx);
      idx = -1;
      for (int t = 0; t < 20; t++) begin
         if (grant != '0) begin
            for (int i = 0; i < N; i++) if (grant[i]) idx = i;
            return;
         end
         tick();
      end
      total++;
      bad++;
      $display("FAIL wait_grant: got no grant expected grant within 20 cycles");
   endtask

   task automatic serve(input int exp_idx, input string nm);
      int g;
      logic [N-1:0] exp_oh;
      wait_grant(g);
      chk(nm, g, exp_idx);
      exp_oh = '0;
      exp_oh[exp_idx] = 1'b1;
      eng_ack = 1'b1;
      eng_result = 16'($urandom);
      tick();
      chk({nm, "_ack"}, ack, exp_oh);
      eng_ack = 1'b0;
      if (g >= 0) req[g] = 1'b0;
      tick();
   endtask

   initial begin
      int g, hi;
      int order [5] = '{0, 1, 2, 3, 0};
      rst = 1'b1; req = '0; eng_ack = 1'b0; eng_nak = 1'b0; eng_result = '0;
      for (int i = 0; i < N; i++) begin
         dm[i] = {40'hD0D0D0D0D0, 8'(i)};
         sm[i] = {40'h5A5A5A5A5A, 8'(i)};
         hs[i] = {4'hA, 8'(i)};
      end
      tick(); tick();
      rst = 1'b0;
      chk("rst_grant", grant, 4'b0000);
      chk("rst_eng_req", eng_req, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_tcnt", timeout_cnt, 16'h0000);

      // single requester, engine answers on the third cycle of eng_req
      req = 4'b0001;
      tick();
      chk("t1_grant", grant, 4'b0001);
      chk("t1_dmac", eng_dmac, 48'hD0D0D0D0D000);
      chk("t1_smac", eng_smac, 48'h5A5A5A5A5A00);
      chk("t1_hash", eng_hash, 12'hA00);
      hi = eng_req ? 1 : 0;
      tick(); hi += eng_req ? 1 : 0;
      tick(); hi += eng_req ? 1 : 0;
      eng_ack = 1'b1; eng_result = 16'h0005;
      tick();
      chk("t1_ack", ack, 4'b0001);
      chk("t1_result", result, 16'h0005);
      chk("t1_ereq_low", eng_req, 1'b0);
      chk("t1_ereq_cycles", hi, 3);
      eng_ack = 1'b0; req = '0;
      tick();
      chk("t1_ack_clear", ack, 4'b0000);

      // round-robin from reset with everyone requesting
      rst = 1'b1; tick(); rst = 1'b0;
      req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         serve(order[n], "t2_rr");
         req[order[n]] = 1'b1;
      end
      req = '0;
      tick();

      // wrap: last_grant=2 then requesters 0 and 1
      req = 4'b0100;
      serve(2, "t3_setup");
      req = 4'b0011;
      serve(0, "t3_wrap0");
      serve(1, "t3_wrap1");

      // timeout with a silent engine, then a late ack that must be ignored
      req = 4'b0001;
      wait_grant(g);
      repeat (7) tick();
      chk("t4_no_early_nak", nak, 4'b0000);
      tick();
      chk("t4_nak", nak, 4'b0001);
      chk("t4_tcnt", timeout_cnt, 16'h0001);
      chk("t4_ereq_low", eng_req, 1'b0);
      req = '0;
      tick();
      eng_ack = 1'b1;
      tick();
      chk("t4_late_ack", ack, 4'b0000);
      eng_ack = 1'b0;
      tick();

      // ack and nak together, then ack exactly on the timeout cycle
      req = 4'b0010;
      wait_grant(g);
      eng_ack = 1'b1; eng_nak = 1'b1; eng_result = 16'h1234;
      tick();
      chk("t5_both_ack", ack, 4'b0010);
      chk("t5_both_nak", nak, 4'b0000);
      chk("t5_both_res", result, 16'h1234);
      eng_ack = 1'b0; eng_nak = 1'b0; req = '0;
      tick();
      req = 4'b0100;
      wait_grant(g);
      repeat (7) tick();
      eng_ack = 1'b1; eng_result = 16'hBEEF;
      tick();
      chk("t5_edge_ack", ack, 4'b0100);
      chk("t5_edge_nak", nak, 4'b0000);
      chk("t5_edge_res", result, 16'hBEEF);
      chk("t5_edge_tcnt", timeout_cnt, 16'h0001);
      eng_ack = 1'b0; req = '0;
      tick();

      // reset while busy, then requester 0 gets the first grant
      req = 4'b1000;
      wait_grant(g);
      chk("t6_pre_grant", grant, 4'b1000);
      rst = 1'b1;
      tick();
      chk("t6_grant", grant, 4'b0000);
      chk("t6_eng_req", eng_req, 1'b0);
      chk("t6_ack_nak", {ack, nak}, 8'h00);
      chk("t6_busy", busy, 1'b0);
      chk("t6_tcnt", timeout_cnt, 16'h0000);
      rst = 1'b0;
      req = 4'b1001;
      serve(0, "t6_first");
      serve(3, "t6_second");
      req = '0;
      tick();

      rand_mode = 1'b1;
      repeat (4000) tick();
      rand_mode = 1'b0;
      rst = 1'b0; req = '0; eng_ack = 1'b0; eng_nak = 1'b0;
      repeat (TO + 4) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
